// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-unit inputs (pipeline stage status) and outputs (stall, flush, forward selects).
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
) ();
   logic [REG_ADDR_W-1:0] i_rs1_addr_dec;
   logic [REG_ADDR_W-1:0] i_rs2_addr_dec;
   logic [REG_ADDR_W-1:0] i_rs1_addr_exec;
   logic [REG_ADDR_W-1:0] i_rs2_addr_exec;
   logic [REG_ADDR_W-1:0] i_rd_addr_exec;
   logic                  i_load_instr_exec;
   logic [REG_ADDR_W-1:0] i_rd_addr_mem;
   logic                  i_reg_we_mem;
   logic [REG_ADDR_W-1:0] i_rd_addr_wb;
   logic                  i_reg_we_wb;
   logic                  i_branch_mispred_exec;
   logic                  i_ecall_exec;
   logic                  i_dcache_miss;
   logic                  i_dcache_ready;
   logic                  i_icache_miss;

   logic [1:0]            o_forward_rs1_exec;
   logic [1:0]            o_forward_rs2_exec;
   logic                  o_stall_fetch;
   logic                  o_stall_dec;
   logic                  o_stall_exec;
   logic                  o_stall_mem;
   logic                  o_stall_wb;
   logic                  o_flush_dec;
   logic                  o_flush_exec;
   logic                  o_trap_redirect;
   logic                  o_trap_active;

   modport master (
      output i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
             i_rd_addr_exec, i_load_instr_exec, i_rd_addr_mem, i_reg_we_mem,
             i_rd_addr_wb, i_reg_we_wb, i_branch_mispred_exec, i_ecall_exec,
             i_dcache_miss, i_dcache_ready, i_icache_miss,
      input  o_forward_rs1_exec, o_forward_rs2_exec, o_stall_fetch, o_stall_dec,
             o_stall_exec, o_stall_mem, o_stall_wb, o_flush_dec, o_flush_exec,
             o_trap_redirect, o_trap_active
   );

   modport slave (
      input  i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec,
             i_rd_addr_exec, i_load_instr_exec, i_rd_addr_mem, i_reg_we_mem,
             i_rd_addr_wb, i_reg_we_wb, i_branch_mispred_exec, i_ecall_exec,
             i_dcache_miss, i_dcache_ready, i_icache_miss,
      output o_forward_rs1_exec, o_forward_rs2_exec, o_stall_fetch, o_stall_dec,
             o_stall_exec, o_stall_mem, o_stall_wb, o_flush_dec, o_flush_exec,
             o_trap_redirect, o_trap_active
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard unit: combinational RAW forwarding, load-use and mispredict handling,
// plus a registered FSM sequencing D-cache/I-cache miss stalls and ecall trap drain/redirect.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W        = 5,
   parameter int TRAP_DRAIN_CYCLES = 2
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   pipeline_hazard_ctrl_if.slave  hz
);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DMISS = 2'd1,
      ST_IMISS = 2'd2,
      ST_TRAP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic stall_fetch, stall_dec, stall_exec, stall_mem, stall_wb;
   logic flush_dec, flush_exec, trap_redirect, trap_active;
   logic load_use;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input logic [REG_ADDR_W-1:0] rd_mem,
                                          input logic                  we_mem,
                                          input logic [REG_ADDR_W-1:0] rd_wb,
                                          input logic                  we_wb);
      // x0 is hardwired to zero and is never forwarded; mem is the younger result.
      if (we_mem && rd_mem != '0 && rd_mem == rs)   return 2'b10;
      else if (we_wb && rd_wb != '0 && rd_wb == rs) return 2'b01;
      else                                          return 2'b00;
   endfunction

   assign load_use = hz.i_load_instr_exec && (hz.i_rd_addr_exec != '0) &&
                     ((hz.i_rd_addr_exec == hz.i_rs1_addr_dec) ||
                      (hz.i_rd_addr_exec == hz.i_rs2_addr_dec));

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      stall_fetch   = 1'b0;
      stall_dec     = 1'b0;
      stall_exec    = 1'b0;
      stall_mem     = 1'b0;
      stall_wb      = 1'b0;
      flush_dec     = 1'b0;
      flush_exec    = 1'b0;
      trap_redirect = 1'b0;
      trap_active   = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (hz.i_dcache_miss) begin
               {stall_fetch, stall_dec, stall_exec, stall_mem, stall_wb} = '1;
               state_d = ST_DMISS;
            end else if (hz.i_ecall_exec) begin
               stall_fetch = 1'b1;
               flush_dec   = 1'b1;
               flush_exec  = 1'b1;
               cnt_d       = CNT_W'(TRAP_DRAIN_CYCLES);
               state_d     = ST_TRAP;
            end else if (hz.i_branch_mispred_exec) begin
               flush_dec  = 1'b1;
               flush_exec = 1'b1;
            end else if (load_use) begin
               stall_fetch = 1'b1;
               stall_dec   = 1'b1;
               flush_exec  = 1'b1;
            end else if (hz.i_icache_miss) begin
               stall_fetch = 1'b1;
               flush_dec   = 1'b1;
               state_d     = ST_IMISS;
            end
         end

         ST_DMISS: begin
            if (hz.i_dcache_ready) begin
               state_d = ST_RUN;
            end else begin
               {stall_fetch, stall_dec, stall_exec, stall_mem, stall_wb} = '1;
            end
         end

         ST_IMISS: begin
            if (hz.i_dcache_miss) begin
               {stall_fetch, stall_dec, stall_exec, stall_mem, stall_wb} = '1;
               state_d = ST_DMISS;
            end else if (hz.i_icache_miss) begin
               stall_fetch = 1'b1;
               flush_dec   = 1'b1;
               flush_exec  = hz.i_branch_mispred_exec;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_TRAP: begin
            trap_active = 1'b1;
            // A D-cache miss freezes the whole drain; flushes are withheld while stalled.
            if (hz.i_dcache_miss) begin
               {stall_fetch, stall_dec, stall_exec, stall_mem, stall_wb} = '1;
            end else begin
               stall_fetch = 1'b1;
               flush_dec   = 1'b1;
               flush_exec  = 1'b1;
               cnt_d       = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  trap_redirect = 1'b1;
                  state_d       = ST_RUN;
               end
            end
         end

         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced low for the whole reset interval, including the forward selects.
   assign hz.o_forward_rs1_exec = i_arst ? 2'b00 :
      fwd_sel(hz.i_rs1_addr_exec, hz.i_rd_addr_mem, hz.i_reg_we_mem, hz.i_rd_addr_wb, hz.i_reg_we_wb);
   assign hz.o_forward_rs2_exec = i_arst ? 2'b00 :
      fwd_sel(hz.i_rs2_addr_exec, hz.i_rd_addr_mem, hz.i_reg_we_mem, hz.i_rd_addr_wb, hz.i_reg_we_wb);
   assign hz.o_stall_fetch   = !i_arst && stall_fetch;
   assign hz.o_stall_dec     = !i_arst && stall_dec;
   assign hz.o_stall_exec    = !i_arst && stall_exec;
   assign hz.o_stall_mem     = !i_arst && stall_mem;
   assign hz.o_stall_wb      = !i_arst && stall_wb;
   assign hz.o_flush_dec     = !i_arst && flush_dec;
   assign hz.o_flush_exec    = !i_arst && flush_exec;
   assign hz.o_trap_redirect = !i_arst && trap_redirect;
   assign hz.o_trap_active   = !i_arst && trap_active;
endmodule
